// File: rtl/burst_dequeueing_unit.sv
// Burst dequeue generator: accepts a channel-select vector plus per-channel
// burst lengths and issues dequeue strobes until every selected channel has
// been dequeued the requested number of times. Empty channels stall
// individually. A synchronous abort cancels the burst in flight.
module burst_dequeueing_unit #(
    parameter int NUM_CHANNELS = 4,
    parameter int COUNT_WIDTH  = 2
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                enable,
    input  logic [NUM_CHANNELS-1:0]             icd,
    input  logic [NUM_CHANNELS*COUNT_WIDTH-1:0] burst_counts,
    input  logic [NUM_CHANNELS-1:0]             channel_empty,
    input  logic                                abort,
    output logic [NUM_CHANNELS-1:0]             dequeue_signals,
    output logic                                ready,
    output logic                                busy,
    output logic                                done,
    output logic                                aborted
);

    // Each remaining counter holds 0..2^COUNT_WIDTH, so it needs one extra bit.
    localparam int RW = COUNT_WIDTH + 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t                  state_r;
    state_t                  state_next_s;
    logic [RW-1:0]           remaining_r      [NUM_CHANNELS];
    logic [RW-1:0]           remaining_next_s [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] strobe_s;
    logic                    any_left_s;
    logic                    done_r;
    logic                    done_next_s;
    logic                    aborted_r;
    logic                    aborted_next_s;

    // Per-channel strobe: pending work, token available, no cancel this cycle.
    always_comb begin
        strobe_s = {NUM_CHANNELS{1'b0}};
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if ((state_r == DRAIN) && (remaining_r[i] != {RW{1'b0}})
                && !channel_empty[i] && !abort) begin
                strobe_s[i] = 1'b1;
            end else begin
                strobe_s[i] = 1'b0;
            end
        end
    end

    // Next-state, counter update and completion/cancel pulse generation.
    always_comb begin
        state_next_s   = state_r;
        done_next_s    = 1'b0;
        aborted_next_s = 1'b0;
        any_left_s     = 1'b0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            remaining_next_s[i] = remaining_r[i];
        end

        case (state_r)
            IDLE: begin
                if (enable && (icd != {NUM_CHANNELS{1'b0}})) begin
                    for (int i = 0; i < NUM_CHANNELS; i++) begin
                        if (icd[i]) begin
                            remaining_next_s[i] =
                                {1'b0, burst_counts[i*COUNT_WIDTH +: COUNT_WIDTH]}
                                + {{COUNT_WIDTH{1'b0}}, 1'b1};
                        end else begin
                            remaining_next_s[i] = {RW{1'b0}};
                        end
                    end
                    state_next_s = DRAIN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            DRAIN: begin
                if (abort) begin
                    for (int i = 0; i < NUM_CHANNELS; i++) begin
                        remaining_next_s[i] = {RW{1'b0}};
                    end
                    aborted_next_s = 1'b1;
                    state_next_s   = IDLE;
                end else begin
                    for (int i = 0; i < NUM_CHANNELS; i++) begin
                        if (strobe_s[i]) begin
                            remaining_next_s[i] = remaining_r[i] - {{COUNT_WIDTH{1'b0}}, 1'b1};
                        end else begin
                            remaining_next_s[i] = remaining_r[i];
                        end
                        any_left_s = any_left_s | (remaining_next_s[i] != {RW{1'b0}});
                    end
                    if (any_left_s) begin
                        state_next_s = DRAIN;
                    end else begin
                        done_next_s  = 1'b1;
                        state_next_s = IDLE;
                    end
                end
            end
            default: begin
                for (int i = 0; i < NUM_CHANNELS; i++) begin
                    remaining_next_s[i] = {RW{1'b0}};
                end
                state_next_s = IDLE;
            end
        endcase
    end

    // State, counters and one-cycle status pulses; reset discards any burst.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            done_r    <= 1'b0;
            aborted_r <= 1'b0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                remaining_r[i] <= {RW{1'b0}};
            end
        end else begin
            state_r   <= state_next_s;
            done_r    <= done_next_s;
            aborted_r <= aborted_next_s;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                remaining_r[i] <= remaining_next_s[i];
            end
        end
    end

    assign dequeue_signals = strobe_s;
    assign ready           = (state_r == IDLE);
    assign busy            = (state_r == DRAIN);
    assign done            = done_r;
    assign aborted         = aborted_r;

endmodule

// File: tb/tb_burst_dequeueing_unit.sv
// Directed bench for burst_dequeueing_unit. Inputs change 1 time unit after
// the rising edge; outputs are sampled 3 time units after the rising edge.
module tb_burst_dequeueing_unit;

    logic       clock;
    logic       reset;
    logic       enable;
    logic [3:0] icd;
    logic [7:0] burst_counts;
    logic [3:0] channel_empty;
    logic       abort;
    logic [3:0] dequeue_signals;
    logic       ready;
    logic       busy;
    logic       done;
    logic       aborted;

    int n_checks = 0;
    int n_pass   = 0;

    burst_dequeueing_unit #(
        .NUM_CHANNELS (4),
        .COUNT_WIDTH  (2)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .enable          (enable),
        .icd             (icd),
        .burst_counts    (burst_counts),
        .channel_empty   (channel_empty),
        .abort           (abort),
        .dequeue_signals (dequeue_signals),
        .ready           (ready),
        .busy            (busy),
        .done            (done),
        .aborted         (aborted)
    );

    // 10-unit clock, rising edges at 5, 15, 25, ...
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] deq, input logic rdy,
                           input logic bsy, input logic dn, input logic ab);
        check_eq({tag, ".deq"},     {28'd0, dequeue_signals}, {28'd0, deq});
        check_eq({tag, ".ready"},   {31'd0, ready},           {31'd0, rdy});
        check_eq({tag, ".busy"},    {31'd0, busy},            {31'd0, bsy});
        check_eq({tag, ".done"},    {31'd0, done},            {31'd0, dn});
        check_eq({tag, ".aborted"}, {31'd0, aborted},         {31'd0, ab});
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; icd = 4'b0000; burst_counts = 8'h00;
        channel_empty = 4'b0000; abort = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        settle();
        chk_out("reset", 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);

        // T1: ch0 x3, ch2 x1
        enable = 1'b1; icd = 4'b0101; burst_counts = 8'b00_00_00_10;
        settle();
        chk_out("t1.accept", 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); enable = 1'b0; icd = 4'b0000; settle();
        chk_out("t1.c1", 4'b0101, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(); settle();
        chk_out("t1.c2", 4'b0001, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(); settle();
        chk_out("t1.c3", 4'b0001, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(); settle();
        chk_out("t1.done", 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0);
        tick(); settle();
        chk_out("t1.after", 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);

        // T2: ch1 x4 with ch1 empty in DRAIN cycles 2-3
        enable = 1'b1; icd = 4'b0010; burst_counts = 8'b00_00_11_00;
        tick(); enable = 1'b0; icd = 4'b0000; settle();
        chk_out("t2.c1", 4'b0010, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(); channel_empty = 4'b0010; settle();
        chk_out("t2.c2", 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(); settle();
        chk_out("t2.c3", 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(); channel_empty = 4'b0000; settle();
        chk_out("t2.c4", 4'b0010, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(); settle();
        chk_out("t2.c5", 4'b0010, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(); settle();
        chk_out("t2.c6", 4'b0010, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(); settle();
        chk_out("t2.done", 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0);

        // T3: ch3 x4, abort after two strobes, then fresh ch3 x2 request
        tick();
        enable = 1'b1; icd = 4'b1000; burst_counts = 8'b11_00_00_00;
        tick(); enable = 1'b0; icd = 4'b0000; settle();
        chk_out("t3.c1", 4'b1000, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(); settle();
        chk_out("t3.c2", 4'b1000, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(); abort = 1'b1; settle();
        chk_out("t3.abort", 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(); abort = 1'b0;
        enable = 1'b1; icd = 4'b1000; burst_counts = 8'b01_00_00_00;
        settle();
        chk_out("t3.aborted", 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1);
        tick(); settle();
        // T4 (first part): request held while busy is ignored
        enable = 1'b1; icd = 4'b0001; burst_counts = 8'b00_00_00_11;
        settle();
        chk_out("t3.new1", 4'b1000, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(); settle();
        chk_out("t3.new2", 4'b1000, 1'b0, 1'b1, 1'b0, 1'b0);
        // Done cycle: back-to-back request ch0 x2, ch2 x2
        tick(); icd = 4'b0101; burst_counts = 8'b00_01_00_01; settle();
        chk_out("t3.done", 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0);
        tick(); enable = 1'b0; icd = 4'b0000; settle();
        chk_out("t4.b2b1", 4'b0101, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(); settle();
        chk_out("t4.b2b2", 4'b0101, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(); settle();
        chk_out("t4.done", 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0);
        tick(); settle();
        chk_out("t4.idle", 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);

        // T5: enable with icd=0 is a no-op; abort in IDLE is harmless
        enable = 1'b1; icd = 4'b0000; burst_counts = 8'hFF; abort = 1'b1;
        settle();
        chk_out("t5.req", 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); enable = 1'b0; abort = 1'b0; settle();
        chk_out("t5.n1", 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); settle();
        chk_out("t5.n2", 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);

        // T6: async reset mid-burst
        enable = 1'b1; icd = 4'b1111; burst_counts = 8'hFF;
        tick(); enable = 1'b0; icd = 4'b0000; settle();
        chk_out("t6.c1", 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0);
        #1 reset = 1'b1;
        #1;
        chk_out("t6.inrst", 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); reset = 1'b0; settle();
        chk_out("t6.rel", 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); settle();
        chk_out("t6.after", 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/burst_dequeueing_unit.md
Name: burst_dequeueing_unit

Overview:
- Sequential successor to the single-shot dequeue generator in the datapath.
- Accepts a channel-select vector plus a per-channel burst length, then issues dequeue strobes over several cycles until every selected channel has been dequeued the requested number of times.
- Holds off a channel's strobes while that channel is empty.
- Sits between the instruction/trigger stage and the input-channel FIFOs; the trigger stage can retire a multi-token consume with a single request.

Parameters:
NUM_CHANNELS, 4, number of input channels (width of icd and dequeue_signals)
COUNT_WIDTH, 2, bits per channel burst field; field value c requests c+1 dequeues (1..2^COUNT_WIDTH)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
enable  input  1  request strobe; sampled only when ready=1
icd  input  NUM_CHANNELS  channels to dequeue in this request
burst_counts  input  NUM_CHANNELS*COUNT_WIDTH  packed burst fields; channel i uses bits [i*COUNT_WIDTH +: COUNT_WIDTH]
channel_empty  input  NUM_CHANNELS  per-channel FIFO empty flags
abort  input  1  synchronous cancel of the in-flight burst
dequeue_signals  output  NUM_CHANNELS  per-channel dequeue strobes, one token per asserted cycle
ready  output  1  unit is idle and accepts a request
busy  output  1  burst in progress
done  output  1  one-cycle pulse: burst completed normally
aborted  output  1  one-cycle pulse: burst cancelled by abort

Behaviour:
- Interface (already decided): one clock, clock; reset is asynchronous and active-high, reset.
- State: per-channel remaining counter, COUNT_WIDTH+1 bits wide. FSM has two states, IDLE and DRAIN.
- Reset, applied at any time including mid-burst:
  - state=IDLE; all counters 0.
  - dequeue_signals=0, done=0, aborted=0, busy=0, ready=1.
  - The in-flight burst is discarded and no pulse is issued.
- ready = (state==IDLE); busy = (state==DRAIN). Both are derived directly from state.
- IDLE:
  - If enable=1 and icd!=0: for each i, remaining[i] <= icd[i] ? field_i+1 : 0; go to DRAIN.
  - If enable=1 and icd==0: no-op. Stay in IDLE; no done pulse.
  - dequeue_signals=0 throughout IDLE.
- Latency: the first dequeue strobe can appear no earlier than the cycle after acceptance.
- DRAIN (combinational strobe): dequeue_signals[i] = (remaining[i]!=0) && !channel_empty[i] && !abort.
- DRAIN (registered update):
  - Each asserted strobe decrements remaining[i] by 1 at the clock edge.
  - Empty channels stall individually; other channels keep draining.
  - Multiple channels may strobe in the same cycle.
- Completion: when every counter would be 0 after this cycle's decrements, go to IDLE and register done=1 for exactly the next cycle.
  - ready is therefore 1 in the same cycle done is 1.
  - A new request accepted in that cycle is legal.
- abort in DRAIN:
  - No strobes that cycle; all counters cleared; go to IDLE.
  - aborted=1 for exactly the next cycle; done is not asserted.
  - abort in IDLE has no effect.
- enable while busy=1 is ignored: no queuing, no state change. The requester must hold the request until ready=1.
- channel_empty changing mid-burst takes effect the same cycle, because strobes are combinational on it.
- done and aborted are never both 1.

Test Plan:
1. Reset, then icd=4'b0101 with fields ch0=2, ch2=0 (3 and 1 dequeues), all channels non-empty -> next cycle strobes 4'b0101; then 4'b0001 for 2 cycles; done pulses the cycle after the 3rd ch0 strobe; busy high for 3 cycles.
2. icd=4'b0010, ch1=3 (4 dequeues), channel_empty[1] high for cycles 2-3 of DRAIN -> exactly 4 ch1 strobes, none while empty; done after the 4th strobe; 6 DRAIN cycles total.
3. Mid-burst abort: icd=4'b1000, ch3=3, abort after 2 strobes -> no strobe in the abort cycle; aborted pulses 1 cycle; done never asserts; ready=1 next cycle; a new request is accepted cleanly with counters starting fresh.
4. New request (icd=4'b0001) presented while busy -> ignored, dequeue pattern unchanged. Back-to-back request in the done cycle -> accepted; strobes resume the following cycle.
5. enable=1 with icd=0 in IDLE -> no strobes, no done, ready stays 1.
6. Async reset asserted mid-burst, between clock edges -> all outputs 0 and ready=1 immediately; no done or aborted after release.
